btn_debounce: RTL and testbench

- Conditions one raw, active-low, bouncing icestick push-button into clean signals.
- Sits directly upstream of the counting FSM and drives its go input with a debounced level and single-cycle press/release pulses.
- Also reusable for the reset and mode buttons; one instance per button.

---
 rtl/btn_pkg.sv | 22 ++
 rtl/btn_sync.sv | 24 ++
 rtl/btn_debounce.sv | 137 +++++++++++++
 tb/tb_btn_debounce.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioning blocks: debounce FSM
// state encoding and default timing constants for a 12 MHz clock.
package btn_pkg;

    typedef enum logic [1:0] {
        ST_RELEASED  = 2'd0,
        ST_ARMING    = 2'd1,
        ST_PRESSED   = 2'd2,
        ST_DISARMING = 2'd3
    } btn_state_t;

    localparam int DEFAULT_SYNC_STAGES     = 2;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 120000;    // 10 ms at 12 MHz
    localparam int DEFAULT_CNT_W           = 17;
    localparam int DEFAULT_HOLD_CYCLES     = 12000000;  // 1 s at 12 MHz

    // The debounced level is asserted in both "pressed-side" states.
    function automatic logic is_pressed_side(input btn_state_t st);
        return (st == ST_PRESSED) || (st == ST_DISARMING);
    endfunction

endpackage

// File: rtl/btn_sync.sv
// Metastability synchronizer for one asynchronous button pin; every stage
// resets to 1 so a released (active-low) button is assumed out of reset.
module btn_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    assign dout = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/btn_debounce.sv
// Debouncer for one active-low push-button: synchronizer, 4-state stability
// FSM, registered level/press/release outputs. Define BTN_DEBOUNCE_LONGPRESS_EN
// to build the long-press (btn_hold) detector; otherwise btn_hold is tied low.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W,
    parameter int HOLD_CYCLES     = DEFAULT_HOLD_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_hold
);

    if ((SYNC_STAGES < 2) || (SYNC_STAGES > 4) || (DEBOUNCE_CYCLES < 2) ||
        (HOLD_CYCLES < 1) || ((longint'(DEBOUNCE_CYCLES) >> CNT_W) != 0)) begin : g_param_check
        $error("btn_debounce: illegal parameter combination");
    end

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic       sync_out;
    logic       s;
    btn_state_t state;
    logic [CNT_W-1:0] cnt;
    logic       accept_press;
    logic       accept_release;

    btn_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .din (btn_n),
        .dout(sync_out)
    );

    assign s = ~sync_out;

    // A change is accepted once the new level has survived the whole window.
    assign accept_press   = (state == ST_ARMING)    &&  s && (cnt == CNT_LAST);
    assign accept_release = (state == ST_DISARMING) && !s && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_RELEASED;
            cnt         <= '0;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
            case (state)
                ST_RELEASED: begin
                    if (s) begin
                        state <= ST_ARMING;
                        cnt   <= '0;
                    end
                end
                ST_ARMING: begin
                    if (!s) begin
                        state <= ST_RELEASED;
                    end else if (accept_press) begin
                        state     <= ST_PRESSED;
                        btn_level <= 1'b1;
                        btn_press <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_PRESSED: begin
                    if (!s) begin
                        state <= ST_DISARMING;
                        cnt   <= '0;
                    end
                end
                ST_DISARMING: begin
                    if (s) begin
                        state <= ST_PRESSED;
                    end else if (accept_release) begin
                        state       <= ST_RELEASED;
                        btn_level   <= 1'b0;
                        btn_release <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_RELEASED;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef BTN_DEBOUNCE_LONGPRESS_EN
    localparam int HCNT_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [HCNT_W-1:0] HOLD_LAST = HCNT_W'(HOLD_CYCLES - 1);

    logic [HCNT_W-1:0] hcnt;
    logic              hold_done;

    // hcnt saturates at HOLD_LAST; hold_done limits btn_hold to one pulse per press.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt      <= '0;
            hold_done <= 1'b0;
            btn_hold  <= 1'b0;
        end else begin
            btn_hold <= 1'b0;
            if (accept_press || accept_release) begin
                hcnt      <= '0;
                hold_done <= 1'b0;
            end else if (is_pressed_side(state)) begin
                if (hcnt == HOLD_LAST) begin
                    if (!hold_done) begin
                        btn_hold  <= 1'b1;
                        hold_done <= 1'b1;
                    end
                end else begin
                    hcnt <= hcnt + 1'b1;
                end
            end
        end
    end
`else
    assign btn_hold = 1'b0;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce: directed scenarios plus randomized
// bounce traffic, all compared against a run-length reference model.
module tb_btn_debounce;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int HOLD = 10;
`ifdef BTN_DEBOUNCE_LONGPRESS_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_n = 1'b1;
    logic btn_level, btn_press, btn_release, btn_hold;

    int tests_run = 0;
    int tests_failed = 0;

    btn_debounce #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (3),
        .HOLD_CYCLES    (HOLD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_n      (btn_n),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_hold   (btn_hold)
    );

    always #5 clk = ~clk;

    // Reference model: the pin is seen SYNC clocks late; the level flips once
    // the seen value has disagreed with it for DEB+1 consecutive clocks.
    bit sh [SYNC];
    bit m_s, m_level, m_fired, m_flip;
    int m_run, m_age;
    logic exp_level = 1'b0, exp_press = 1'b0, exp_release = 1'b0, exp_hold = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SYNC; k++) sh[k] = 1'b1;
            m_level = 1'b0; m_run = 0; m_age = 0; m_fired = 1'b0;
            exp_level = 1'b0; exp_press = 1'b0; exp_release = 1'b0; exp_hold = 1'b0;
        end else begin
            m_s = !sh[SYNC-1];
            for (int k = SYNC - 1; k > 0; k--) sh[k] = sh[k-1];
            sh[0] = btn_n;
            exp_press = 1'b0; exp_release = 1'b0; exp_hold = 1'b0; m_flip = 1'b0;
            if (m_s != m_level) begin
                m_run++;
                if (m_run == DEB + 1) begin
                    m_level = m_s; m_run = 0; m_flip = 1'b1;
                    exp_press = m_level; exp_release = !m_level;
                end
            end else begin
                m_run = 0;
            end
            if (m_flip) begin
                m_age = 0; m_fired = 1'b0;
            end else if (m_level) begin
                if (m_age < HOLD) m_age++;
                if (m_age == HOLD && !m_fired) begin
                    exp_hold = HOLD_EN; m_fired = 1'b1;
                end
            end
            exp_level = m_level;
        end
    end

    task automatic drive_idle(input logic v, input int n);
        btn_n = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; btn_n = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({btn_level, btn_press, btn_release, btn_hold} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b expected 0000", {btn_level, btn_press, btn_release, btn_hold});
        end
        tests_run++;
        if (dut.state !== btn_pkg::ST_RELEASED) begin
            tests_failed++;
            $display("FAIL reset_state: got %0d expected 0", dut.state);
        end
        rst = 1'b0;
        drive_idle(1'b1, 4);
    endtask

    task automatic test_clean_press();
        int rise_at = -1, n_press = 0, n_rel = 0;
        for (int i = 1; i <= 20; i++) begin
            btn_n = 1'b0;
            @(negedge clk);
            tests_run++;
            if ({btn_level, btn_press, btn_release, btn_hold} !== {exp_level, exp_press, exp_release, exp_hold}) begin
                tests_failed++;
                $display("FAIL clean_press edge %0d: got %b expected %b", i,
                         {btn_level, btn_press, btn_release, btn_hold}, {exp_level, exp_press, exp_release, exp_hold});
            end
            if (btn_level === 1'b1 && rise_at < 0) rise_at = i;
            n_press += int'(btn_press === 1'b1);
            n_rel   += int'(btn_release === 1'b1);
        end
        tests_run++;
        if (rise_at != 7 || n_press != 1 || n_rel != 0) begin
            tests_failed++;
            $display("FAIL clean_press_latency: rise edge %0d presses %0d releases %0d expected 7/1/0", rise_at, n_press, n_rel);
        end
    endtask

    task automatic test_bounce_reject();
        int n_evt = 0;
        logic pat [14] = '{0,0,0,1,0,0,0,1,1,1,1,1,1,1};
        drive_idle(1'b1, 12);
        for (int i = 0; i < 14; i++) begin
            btn_n = pat[i];
            @(negedge clk);
            tests_run++;
            if ({btn_level, btn_press, btn_release} !== {exp_level, exp_press, exp_release}) begin
                tests_failed++;
                $display("FAIL bounce_reject step %0d: got %b expected %b", i,
                         {btn_level, btn_press, btn_release}, {exp_level, exp_press, exp_release});
            end
            n_evt += int'(btn_level === 1'b1) + int'(btn_press === 1'b1) + int'(btn_release === 1'b1);
        end
        tests_run++;
        if (n_evt != 0) begin
            tests_failed++;
            $display("FAIL bounce_reject_quiet: got %0d output events expected 0", n_evt);
        end
    endtask

    task automatic test_clean_release();
        int fall_at, n_rel, n_press;
        logic pat [20];
        for (int pass = 0; pass < 2; pass++) begin
            drive_idle(1'b0, 12);
            fall_at = -1; n_rel = 0; n_press = 0;
            for (int i = 0; i < 20; i++) pat[i] = (pass == 1 && (i == 3 || i == 4)) ? 1'b0 : 1'b1;
            for (int i = 1; i <= 20; i++) begin
                btn_n = pat[i-1];
                @(negedge clk);
                tests_run++;
                if ({btn_level, btn_press, btn_release, btn_hold} !== {exp_level, exp_press, exp_release, exp_hold}) begin
                    tests_failed++;
                    $display("FAIL clean_release pass %0d edge %0d: got %b expected %b", pass, i,
                             {btn_level, btn_press, btn_release, btn_hold}, {exp_level, exp_press, exp_release, exp_hold});
                end
                if (btn_level === 1'b0 && fall_at < 0) fall_at = i;
                n_rel   += int'(btn_release === 1'b1);
                n_press += int'(btn_press === 1'b1);
            end
            tests_run++;
            if (fall_at != (pass == 0 ? 7 : 12) || n_rel != 1 || n_press != 0) begin
                tests_failed++;
                $display("FAIL release_latency pass %0d: fall edge %0d releases %0d presses %0d expected %0d/1/0",
                         pass, fall_at, n_rel, n_press, (pass == 0 ? 7 : 12));
            end
        end
    endtask

    task automatic test_reset_mid_arming();
        int press_at = -1;
        drive_idle(1'b1, 12);
        btn_n = 1'b0;
        repeat (5) @(negedge clk);
        tests_run++;
        if (dut.cnt !== 3'd2) begin
            tests_failed++;
            $display("FAIL mid_arming_cnt: got %0d expected 2", dut.cnt);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests_run++;
        if ({btn_level, btn_press, btn_release, btn_hold} !== 4'b0000 || dut.state !== btn_pkg::ST_RELEASED) begin
            tests_failed++;
            $display("FAIL mid_arming_reset: got outputs %b state %0d expected 0000 state 0",
                     {btn_level, btn_press, btn_release, btn_hold}, dut.state);
        end
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            tests_run++;
            if ({btn_level, btn_press, btn_release} !== {exp_level, exp_press, exp_release}) begin
                tests_failed++;
                $display("FAIL mid_arming edge %0d: got %b expected %b", i,
                         {btn_level, btn_press, btn_release}, {exp_level, exp_press, exp_release});
            end
            if (btn_press === 1'b1 && press_at < 0) press_at = i;
        end
        tests_run++;
        if (press_at != 7) begin
            tests_failed++;
            $display("FAIL mid_arming_latency: press edge %0d expected 7", press_at);
        end
    endtask

    task automatic test_held_through_reset();
        int press_at = -1, n_press = 0;
        drive_idle(1'b0, 15);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        tests_run++;
        if ({btn_level, btn_press, btn_release, btn_hold} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL held_reset_outputs: got %b expected 0000", {btn_level, btn_press, btn_release, btn_hold});
        end
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (btn_press === 1'b1) begin
                n_press++;
                if (press_at < 0) press_at = i;
            end
        end
        tests_run++;
        if (press_at != 7 || n_press != 1) begin
            tests_failed++;
            $display("FAIL held_through_reset: press edge %0d count %0d expected 7/1", press_at, n_press);
        end
    endtask

    task automatic test_long_press();
        int press_at = -1, hold_at = -1, n_hold = 0;
        drive_idle(1'b1, 12);
        for (int i = 1; i <= 30; i++) begin
            btn_n = 1'b0;
            @(negedge clk);
            tests_run++;
            if (btn_hold !== exp_hold) begin
                tests_failed++;
                $display("FAIL long_press edge %0d: hold %b expected %b", i, btn_hold, exp_hold);
            end
            if (btn_press === 1'b1 && press_at < 0) press_at = i;
            if (btn_hold === 1'b1) begin
                n_hold++;
                if (hold_at < 0) hold_at = i;
            end
        end
        tests_run++;
        if (HOLD_EN ? (n_hold != 1 || hold_at - press_at != HOLD) : (n_hold != 0)) begin
            tests_failed++;
            $display("FAIL long_press_count: holds %0d offset %0d expected %0d holds offset %0d",
                     n_hold, hold_at - press_at, int'(HOLD_EN), HOLD);
        end
    endtask

    task automatic test_random();
        int seg = 0;
        for (int i = 0; i < 3000; i++) begin
            if (seg == 0) begin
                btn_n = ~btn_n;
                seg = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 30)) : int'($urandom_range(1, 6));
            end
            seg--;
            rst = ($urandom_range(0, 299) == 0);
            @(negedge clk);
            tests_run++;
            if ({btn_level, btn_press, btn_release, btn_hold} !== {exp_level, exp_press, exp_release, exp_hold}) begin
                tests_failed++;
                $display("FAIL random cycle %0d: got %b expected %b", i,
                         {btn_level, btn_press, btn_release, btn_hold}, {exp_level, exp_press, exp_release, exp_hold});
            end
            tests_run++;
            if (btn_press === 1'b1 && btn_release === 1'b1) begin
                tests_failed++;
                $display("FAIL random_exclusive cycle %0d: press and release both 1, expected at most one", i);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_clean_press();
        test_bounce_reject();
        test_clean_release();
        test_reset_mid_arming();
        test_held_through_reset();
        test_long_press();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
